// File: rtl/zero_run_sequencer_if.sv
// zero_run_sequencer_if: instruction issue bus between sequencer, program ROM and datapath
`timescale 1ns/1ps
interface zero_run_sequencer_if #(parameter int IP_WIDTH = 12);
   logic [IP_WIDTH-1:0] ip;
   logic [1:0]          op_kind;
   logic [IP_WIDTH-1:0] op_target;
   logic                exec_valid;
   logic                exec_ready;
   logic                cond_zero;
   modport master (output ip, exec_valid, input op_kind, op_target, exec_ready, cond_zero);
   modport slave  (input ip, exec_valid, output op_kind, op_target, exec_ready, cond_zero);
endinterface

// File: rtl/zero_run_sequencer.sv
// zero_run_sequencer: owns ip/step count, issues one instruction per handshake,
// resolves jumps, detects program end or runaway loop and latches the run result
`timescale 1ns/1ps
module zero_run_sequencer #(
   parameter int IP_WIDTH   = 12,
   parameter int NINSTR     = 6,
   parameter int STEP_WIDTH = 16,
   parameter int MAX_STEPS  = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic                  i_check_pass,
   zero_run_sequencer_if.master  bus,
   output logic [STEP_WIDTH-1:0] o_steps,
   output logic                  o_finished,
   output logic                  o_success,
   output logic                  o_timeout
);
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
   state_t                r_state, w_state_nxt;
   logic [IP_WIDTH-1:0]   r_ip, w_ip_nxt, w_ip_jmp;
   logic [STEP_WIDTH-1:0] r_steps, w_steps_nxt, w_steps_inc;
   logic                  r_finished, r_success, r_timeout;
   logic                  w_fin_nxt, w_suc_nxt, w_to_nxt;
   logic                  w_valid, w_in_prog, w_take;
   assign w_in_prog   = r_ip < IP_WIDTH'(NINSTR);
   assign w_valid     = (r_state == ISSUE) && w_in_prog;
   assign w_steps_inc = r_steps + 1'b1;
   // kind 2 jumps when the compare was zero, kind 3 when it was not
   assign w_take      = (bus.op_kind == 2'd1) || (bus.op_kind == 2'd2 && bus.cond_zero) ||
                        (bus.op_kind == 2'd3 && !bus.cond_zero);
   assign w_ip_jmp    = w_take ? bus.op_target : r_ip + 1'b1;
   assign bus.ip         = r_ip;
   assign bus.exec_valid = w_valid;
   assign o_steps        = r_steps;
   assign o_finished     = r_finished;
   assign o_success      = r_success;
   assign o_timeout      = r_timeout;
   always_comb begin
      w_state_nxt = r_state;
      w_ip_nxt    = r_ip;
      w_steps_nxt = r_steps;
      w_fin_nxt   = r_finished;
      w_suc_nxt   = r_success;
      w_to_nxt    = r_timeout;
      case (r_state)
         IDLE, DONE: if (i_start) begin
            w_state_nxt = ISSUE;
            w_ip_nxt    = '0;
            w_steps_nxt = '0;
            w_fin_nxt   = 1'b0;
            w_suc_nxt   = 1'b0;
            w_to_nxt    = 1'b0;
         end
         ISSUE: if (!w_in_prog) begin
            w_state_nxt = DONE;
            w_fin_nxt   = 1'b1;
            w_suc_nxt   = i_check_pass;
            w_to_nxt    = 1'b0;
         end else if (bus.exec_ready) begin
            w_steps_nxt = w_steps_inc;
            w_ip_nxt    = w_ip_jmp;
            // hitting the limit while still inside the program is a runaway loop
            if (w_steps_inc == STEP_WIDTH'(MAX_STEPS) && w_ip_jmp < IP_WIDTH'(NINSTR)) begin
               w_state_nxt = DONE;
               w_fin_nxt   = 1'b1;
               w_suc_nxt   = 1'b0;
               w_to_nxt    = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ip       <= '0;
         r_steps    <= '0;
         r_finished <= 1'b0;
         r_success  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ip       <= w_ip_nxt;
         r_steps    <= w_steps_nxt;
         r_finished <= w_fin_nxt;
         r_success  <= w_suc_nxt;
         r_timeout  <= w_to_nxt;
      end
   end
endmodule
